inst_memory_loadable: RTL and testbench
=======================================

Name: inst_memory_loadable

Overview:
Parametrised, synchronous instruction memory for the RV32I core with a byte-stream program loader. The core fetches through a registered read port with a one-cycle latency. A host, such as a UART receiver, streams little-endian program bytes into the array, replacing hard-coded debug programs. It sits between the fetch stage (PC) and the IF/ID register.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words (512 bytes); must be a power of two, >= 4.
ADDR_W, 32, width of the fetch byte address (PC).
BASE_ADDR, 32'h0, byte address mapped to word 0.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
fetch_req  in  1  fetch request; accepted when fetch_req && fetch_ready.
fetch_addr  in  ADDR_W  byte address (PC) of the fetch.
fetch_ready  out  1  high when state == IDLE.
fetch_valid  out  1  one-cycle pulse; result of the fetch accepted in the previous cycle.
fetch_inst  out  32  instruction word; 32'h00000013 (NOP) when fetch_err = 1.
fetch_err  out  1  accepted address misaligned (addr[1:0] != 0) or outside BASE_ADDR .. BASE_ADDR + 4*DEPTH_WORDS - 1.
ld_start  in  1  pulse; begins or restarts a load at word 0.
ld_valid  in  1  byte-stream valid.
ld_data  in  8  program byte; first byte of a word goes to bits 7:0.
ld_last  in  1  qualifies the final byte of the program.
ld_ready  out  1  high in LOAD.
ld_busy  out  1  high in LOAD.
ld_words  out  $clog2(DEPTH_WORDS)+1  count of words written by the current or last load.
ld_ovf  out  1  sticky; set when the array filled before ld_last; cleared by ld_start.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - State goes to IDLE.
  - fetch_valid = 0, fetch_err = 0, fetch_inst = 32'h00000013.
  - ld_words = 0, ld_ovf = 0, byte_cnt = 0, word_ptr = 0.
  - Memory contents are NOT cleared.
  - A reset during LOAD aborts the load and discards any partial word.
- State machine:
  - IDLE --ld_start--> LOAD. On entry: word_ptr = 0, byte_cnt = 0, ld_words = 0, ld_ovf = 0.
  - LOAD --accepted byte with ld_last--> IDLE.
  - LOAD --write of word DEPTH_WORDS-1 without ld_last--> IDLE, with ld_ovf = 1.
  - ld_start while in LOAD restarts the load: pointers go to 0, any partial word is discarded, and a byte on ld_data in that same cycle is ignored.
- Loader datapath:
  - A byte is accepted when ld_valid && ld_ready.
  - Each accepted byte is placed in lane byte_cnt and byte_cnt increments.
  - On the 4th byte, the assembled word is written to mem[word_ptr] in the same edge; word_ptr and ld_words increment.
  - ld_last on a byte with byte_cnt < 3: the word is written with the remaining upper lanes zero-filled, and ld_words increments.
  - ld_valid outside LOAD is ignored.
- Fetch:
  - Read is synchronous. Request accepted at edge N produces fetch_valid = 1 at edge N+1 with fetch_inst = mem[(fetch_addr - BASE_ADDR) >> 2].
  - Back-to-back requests give one result per cycle.
  - fetch_ready = 0 in LOAD, so fetch_req is ignored and fetch_valid stays 0 in the following cycle.
  - fetch_inst holds its last value while fetch_valid = 0.
- Simultaneous events:
  - ld_start and fetch_req in the same IDLE cycle: the fetch is accepted (fetch_ready was 1) and completes normally.
  - The state then goes to LOAD.
- Width rules:
  - Index = (fetch_addr - BASE_ADDR)[ $clog2(DEPTH_WORDS)+1 : 2 ].
  - The range check uses the full ADDR_W subtraction with a borrow bit, so an address below BASE_ADDR flags fetch_err.

Decomposition:
- Shared header inst_mem_defs.vh holds:
  - state encodings LD_IDLE = 2'd0, LD_LOAD = 2'd1;
  - the NOP constant 32'h00000013;
  - the byte-lane width.
- One sub-module, inst_byte_packer: holds byte_cnt and the lane registers, and emits word_valid and word_data for 4 bytes or for last-with-zero-fill.
- inst_memory_loadable holds the array, the FSM, word_ptr and the fetch port.

Test Plan:
1. Reset, then fetch 0x0 -> fetch_valid one cycle later, fetch_err = 0, ld_words = 0, fetch_ready = 1.
2. ld_start; stream 93 00 10 00 13 01 A0 00 with ld_last on the final byte -> ld_words = 2; fetch 0x0 gives 0x00100093 and fetch 0x4 gives 0x00A00113, each at latency 1.
3. Load 5 bytes 01 02 03 04 05 with ld_last on 05 -> mem[1] = 0x00000005, ld_words = 2, ld_ovf = 0.
4. Stream 4*DEPTH_WORDS + 4 bytes with no ld_last -> ld_ovf = 1, ld_words = DEPTH_WORDS, ld_ready drops after byte 4*DEPTH_WORDS, and later bytes are not written.
5. Fetch 0x2 and fetch 4*DEPTH_WORDS -> fetch_err = 1, fetch_inst = 0x00000013. Fetch during LOAD -> fetch_ready = 0 and fetch_valid stays 0.
6. Assert rst_n = 0 after 2 bytes of a load -> IDLE, ld_words = 0, previously loaded words intact. ld_start mid-word -> the partial word is discarded, and the next word lands at index 0.

Source files
------------

// File: rtl/inst_memory_loadable_pkg.sv
// inst_memory_loadable_pkg: shared loader state encodings and constants
package inst_memory_loadable_pkg;
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1
  } ld_state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int LANE_W = 8;
endpackage

// File: rtl/inst_byte_packer.sv
// inst_byte_packer: assembles little-endian bytes into 32-bit words, zero-filling a short final word
module inst_byte_packer
  import inst_memory_loadable_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [LANE_W-1:0] byte_data,
  input  logic              byte_last,
  output logic              word_valid,
  output logic [31:0]       word_data
);
  logic [1:0] byte_cnt;
  logic [2:0][LANE_W-1:0] lanes;
  assign word_valid = byte_en && (byte_cnt == 2'd3 || byte_last);
  always_comb begin
    word_data = '0;
    for (int i = 0; i < 3; i++)
      word_data[i*LANE_W +: LANE_W] = 2'(i) < byte_cnt ? lanes[i] : (2'(i) == byte_cnt ? byte_data : '0);
    word_data[3*LANE_W +: LANE_W] = byte_cnt == 2'd3 ? byte_data : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n || clr) byte_cnt <= '0;
    else if (byte_en) byte_cnt <= word_valid ? 2'd0 : byte_cnt + 2'd1;
  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (byte_en && byte_cnt == 2'(i)) lanes[i] <= byte_data;
endmodule

// File: rtl/inst_memory_loadable.sv
// inst_memory_loadable: instruction memory with registered fetch port and byte-stream loader
module inst_memory_loadable
  import inst_memory_loadable_pkg::*;
#(
  parameter int                DEPTH_WORDS = 128,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_req,
  input  logic [ADDR_W-1:0]            fetch_addr,
  output logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [31:0]                  fetch_inst,
  output logic                         fetch_err,
  input  logic                         ld_start,
  input  logic                         ld_valid,
  input  logic [7:0]                   ld_data,
  input  logic                         ld_last,
  output logic                         ld_ready,
  output logic                         ld_busy,
  output logic [$clog2(DEPTH_WORDS):0] ld_words,
  output logic                         ld_ovf
);
  localparam int PW = $clog2(DEPTH_WORDS);
  ld_state_t state, state_nx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [PW-1:0] word_ptr;
  logic [ADDR_W:0] diff;
  logic accept, word_valid, wrap, fetch_acc, addr_err;
  logic [31:0] word_data;
  assign ld_ready    = state == LD_LOAD;
  assign ld_busy     = ld_ready;
  assign fetch_ready = state == LD_IDLE;
  assign fetch_acc   = fetch_req && fetch_ready;
  // a restart in LOAD drops the byte offered in the same cycle
  assign accept      = ld_valid && ld_ready && !ld_start;
  assign wrap        = word_ptr == PW'(DEPTH_WORDS - 1);
  // extra borrow bit makes addresses below BASE_ADDR out of range
  assign diff        = {1'b0, fetch_addr} - {1'b0, BASE_ADDR};
  assign addr_err    = diff[ADDR_W] || |diff[1:0] || |diff[ADDR_W-1:PW+2];
  inst_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (ld_start),
    .byte_en    (accept),
    .byte_data  (ld_data),
    .byte_last  (ld_last),
    .word_valid (word_valid),
    .word_data  (word_data)
  );
  always_comb begin
    state_nx = state;
    if (ld_start) state_nx = LD_LOAD;
    else if (state == LD_LOAD && word_valid && (ld_last || wrap)) state_nx = LD_IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= LD_IDLE;
      word_ptr <= '0;
      ld_words <= '0;
      ld_ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (ld_start) begin
        word_ptr <= '0;
        ld_words <= '0;
        ld_ovf   <= 1'b0;
      end else if (word_valid) begin
        word_ptr <= word_ptr + 1'b1;
        ld_words <= ld_words + 1'b1;
        ld_ovf   <= ld_ovf || (wrap && !ld_last);
      end
    end
  always_ff @(posedge clk)
    if (rst_n && word_valid) mem[word_ptr] <= word_data;
  always_ff @(posedge clk)
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_inst  <= NOP;
    end else begin
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_err  <= addr_err;
        fetch_inst <= addr_err ? NOP : mem[diff[PW+1:2]];
      end
    end
endmodule

// File: tb/tb_inst_memory_loadable.sv
// tb_inst_memory_loadable: directed self-checking bench for the loadable instruction memory
module tb_inst_memory_loadable;
  localparam int D = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic fetch_req = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic [7:0] ld_data = '0;
  logic fetch_ready, fetch_valid, fetch_err, ld_ready, ld_busy, ld_ovf;
  logic [31:0] fetch_inst;
  logic [$clog2(D):0] ld_words;
  int checks = 0, errors = 0;

  inst_memory_loadable #(.DEPTH_WORDS(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_err(fetch_err),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_words(ld_words), .ld_ovf(ld_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic err);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    check({tag, "_valid"}, {31'b0, fetch_valid}, 32'd1);
    check({tag, "_err"}, {31'b0, fetch_err}, {31'b0, err});
    check({tag, "_inst"}, fetch_inst, exp);
  endtask

  initial begin
    step();
    step();
    check("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
    check("rst_inst", fetch_inst, 32'h13);
    check("rst_words", 32'(ld_words), 32'd0);
    check("rst_ovf", {31'b0, ld_ovf}, 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_ready", {31'b0, fetch_ready}, 32'd1);
    check("idle_ld_ready", {31'b0, ld_ready}, 32'd0);
    fetch_req = 1'b1;
    fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    check("f0_valid", {31'b0, fetch_valid}, 32'd1);
    check("f0_err", {31'b0, fetch_err}, 32'd0);
    step();
    check("f0_pulse", {31'b0, fetch_valid}, 32'd0);

    start();
    check("load_busy", {31'b0, ld_busy}, 32'd1);
    check("load_fready", {31'b0, fetch_ready}, 32'd0);
    send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h01, 0); send(8'hA0, 0); send(8'h00, 1);
    check("p1_words", 32'(ld_words), 32'd2);
    check("p1_busy", {31'b0, ld_busy}, 32'd0);
    fetch_req = 1'b1;
    fetch_addr = 32'h0;
    step();
    check("b2b0_valid", {31'b0, fetch_valid}, 32'd1);
    check("b2b0_inst", fetch_inst, 32'h0010_0093);
    fetch_addr = 32'h4;
    step();
    fetch_req = 1'b0;
    check("b2b1_valid", {31'b0, fetch_valid}, 32'd1);
    check("b2b1_inst", fetch_inst, 32'h00A0_0113);

    start();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 1);
    check("p2_words", 32'(ld_words), 32'd2);
    check("p2_ovf", {31'b0, ld_ovf}, 32'd0);
    fetch("p2_w1", 32'h4, 32'h0000_0005, 1'b0);
    fetch("p2_w0", 32'h0, 32'h0403_0201, 1'b0);

    start();
    for (int i = 0; i < 4 * D + 4; i++) begin
      send(8'(i), 0);
      if (i == 4 * D - 2) check("ovf_ready_before", {31'b0, ld_ready}, 32'd1);
      if (i == 4 * D - 1) check("ovf_ready_after", {31'b0, ld_ready}, 32'd0);
    end
    check("ovf_flag", {31'b0, ld_ovf}, 32'd1);
    check("ovf_words", 32'(ld_words), D);
    fetch("ovf_w0", 32'h0, 32'h0302_0100, 1'b0);
    fetch("ovf_w1", 32'h4, 32'h0706_0504, 1'b0);

    fetch("mis", 32'h2, 32'h13, 1'b1);
    fetch("last_ok", 32'(4 * D - 4), 32'h3F3E_3D3C, 1'b0);
    fetch("oor", 32'(4 * D), 32'h13, 1'b1);
    fetch("last_ok2", 32'(4 * D - 4), 32'h3F3E_3D3C, 1'b0);

    start();
    fetch_req = 1'b1;
    fetch_addr = 32'h0;
    check("ld_fready", {31'b0, fetch_ready}, 32'd0);
    step();
    fetch_req = 1'b0;
    check("ld_fvalid", {31'b0, fetch_valid}, 32'd0);
    check("ld_fhold", fetch_inst, 32'h3F3E_3D3C);
    send(8'hAA, 0); send(8'hBB, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", {31'b0, ld_busy}, 32'd0);
    check("abort_words", 32'(ld_words), 32'd0);
    fetch("abort_w0", 32'h0, 32'h0302_0100, 1'b0);

    start();
    send(8'h11, 0); send(8'h22, 0);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data = 8'h99;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    check("restart_busy", {31'b0, ld_busy}, 32'd1);
    check("restart_words", 32'(ld_words), 32'd0);
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 1);
    check("restart_words2", 32'(ld_words), 32'd1);
    fetch("restart_w0", 32'h0, 32'h1234_5678, 1'b0);
    fetch("restart_w1", 32'h4, 32'h0706_0504, 1'b0);

    fetch_req = 1'b1;
    fetch_addr = 32'h0;
    ld_start = 1'b1;
    step();
    fetch_req = 1'b0;
    ld_start = 1'b0;
    check("sim_valid", {31'b0, fetch_valid}, 32'd1);
    check("sim_inst", fetch_inst, 32'h1234_5678);
    check("sim_busy", {31'b0, ld_busy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
